// File: rtl/calc_arbiter.sv
// calc_arbiter: round-robin arbiter/sequencer sharing one 2-bit add/multiply
// unit and its seven-segment decoder between two requesters.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   req0/a0/b0/op0     requester 0: level request, operands, op (1=add, 0=mul)
//   req1/a1/b1/op1     requester 1: level request, operands, op (1=add, 0=mul)
//   gnt0, gnt1         registered one-cycle grant, high during COMPUTE only
//   busy               high while in COMPUTE or HOLD
//   owner              requester whose result is displayed
//   result             latched 4-bit result (zero-extended)
//   salida             segments {g,f,e,d,c,b,a}, active high, decoded from result
module calc_arbiter #(
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int CNT_W       = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [1:0] a0,
    input  logic [1:0] b0,
    input  logic       op0,
    input  logic       req1,
    input  logic [1:0] a1,
    input  logic [1:0] b1,
    input  logic       op1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy,
    output logic       owner,
    output logic [3:0] result,
    output logic [6:0] salida
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    function automatic logic [6:0] dec4a7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic [1:0]       a_q, a_d;
    logic [1:0]       b_q, b_d;
    logic             op_q, op_d;
    logic [3:0]       result_q, result_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             busy_q, busy_d;

    logic             sel_valid;
    logic             sel;
    logic [3:0]       sum_w;
    logic [3:0]       prod_w;

    // On a tie the requester that was not served last wins.
    assign sel_valid = req0 | req1;
    assign sel       = (req0 & req1) ? ~last_q : req1;

    assign sum_w  = {2'b00, a_q} + {2'b00, b_q};
    assign prod_w = {2'b00, a_q} * {2'b00, b_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            a_q      <= 2'b00;
            b_q      <= 2'b00;
            op_q     <= 1'b0;
            result_q <= 4'h0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        last_d   = last_q;
        owner_d  = owner_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        if (state_q == IDLE && sel_valid) begin
            owner_d = sel;
            last_d  = sel;
            a_d     = sel ? a1 : a0;
            b_d     = sel ? b1 : b0;
            op_d    = sel ? op1 : op0;
        end
        if (state_q == COMPUTE) begin
            result_d = op_q ? sum_w : prod_w;
        end
        // Grants and busy are registered from the next state so they
        // line up exactly with the COMPUTE / HOLD cycles.
        gnt0_d = (state_d == COMPUTE) && !owner_d;
        gnt1_d = (state_d == COMPUTE) && owner_d;
        busy_d = (state_d != IDLE);
    end

    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign busy   = busy_q;
    assign owner  = owner_q;
    assign result = result_q;
    assign salida = dec4a7(result_q);

endmodule

// File: tb/tb_calc_arbiter.sv
// tb_calc_arbiter: self-checking bench for calc_arbiter with HOLD_CYCLES=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_calc_arbiter;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, op0, req1, op1;
    logic [1:0] a0, b0, a1, b1;
    logic       gnt0, gnt1, busy, owner;
    logic [3:0] result;
    logic [6:0] salida;

    typedef struct packed {
        logic       owner;
        logic [3:0] res;
    } exp_t;

    exp_t sb[$];
    int   vecs = 0;
    int   errs = 0;

    calc_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(25)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .op0(op0),
        .req1(req1), .a1(a1), .b1(b1), .op1(op1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .owner(owner),
        .result(result), .salida(salida)
    );

    always #5 clk = ~clk;

    // Segments built from the lit-segment letters of each digit.
    function automatic logic [6:0] seg(input int v);
        string s;
        logic [6:0] r;
        case (v)
            0: s = "abcdef";
            1: s = "bc";
            2: s = "abdeg";
            3: s = "abcdg";
            4: s = "bcfg";
            5: s = "acdfg";
            6: s = "acdefg";
            7: s = "abc";
            8: s = "abcdefg";
            9: s = "abcdfg";
            default: s = "";
        endcase
        r = 7'h00;
        for (int i = 0; i < s.len(); i++) begin
            r[int'(s[i]) - 97] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [3:0] model(input int a, input int b, input bit op);
        return op ? 4'(a + b) : 4'(a * b);
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set0(input bit r, input int a, input int b, input bit op);
        req0 = r; a0 = 2'(a); b0 = 2'(b); op0 = op;
    endtask

    task automatic set1(input bit r, input int a, input int b, input bit op);
        req1 = r; a1 = 2'(a); b1 = 2'(b); op1 = op;
    endtask

    task automatic post(input bit who, input int a, input int b, input bit op);
        exp_t e;
        e.owner = who;
        e.res   = model(a, b, op);
        sb.push_back(e);
    endtask

    task automatic wait_gnt(output int n);
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (gnt0 || gnt1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_idle(output int n);
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (!busy) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        tick();
        tick();
        vecs++; if (gnt0 !== 1'b0) begin errs++; $display("FAIL reset_gnt0: got %b want 0", gnt0); end
        vecs++; if (gnt1 !== 1'b0) begin errs++; $display("FAIL reset_gnt1: got %b want 0", gnt1); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
        vecs++; if (owner !== 1'b0) begin errs++; $display("FAIL reset_owner: got %b want 0", owner); end
        vecs++; if (result !== 4'd0) begin errs++; $display("FAIL reset_result: got %0d want 0", result); end
        vecs++; if (salida !== seg(0)) begin errs++; $display("FAIL reset_salida: got %h want %h", salida, seg(0)); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_mul();
        exp_t e;
        int bc;
        set0(1, 3, 3, 0);
        post(0, 3, 3, 0);
        tick();
        vecs++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errs++; $display("FAIL mul_gnt: got %b%b want 10", gnt0, gnt1); end
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL mul_busy_rise: got %b want 1", busy); end
        set0(0, 0, 0, 0);
        bc = 1;
        tick();
        vecs++; if (gnt0 !== 1'b0) begin errs++; $display("FAIL mul_gnt_width: got %b want 0", gnt0); end
        e = sb.pop_front();
        vecs++; if (result !== e.res) begin errs++; $display("FAIL mul_result: got %0d want %0d", result, e.res); end
        vecs++; if (salida !== seg(int'(e.res))) begin errs++; $display("FAIL mul_salida: got %h want %h", salida, seg(int'(e.res))); end
        vecs++; if (owner !== e.owner) begin errs++; $display("FAIL mul_owner: got %b want %b", owner, e.owner); end
        for (int i = 0; i < 20 && busy; i++) begin
            bc++;
            tick();
        end
        vecs++; if (bc != HOLD + 1) begin errs++; $display("FAIL mul_busy_len: got %0d want %0d", bc, HOLD + 1); end
    endtask

    task automatic test_add_zero();
        exp_t e;
        int n;
        set0(1, 3, 3, 1);
        post(0, 3, 3, 1);
        wait_gnt(n);
        vecs++; if (n < 0 || gnt0 !== 1'b1) begin errs++; $display("FAIL add_gnt: got n=%0d gnt0=%b want gnt0=1", n, gnt0); end
        set0(0, 0, 0, 0);
        tick();
        e = sb.pop_front();
        vecs++; if (result !== e.res) begin errs++; $display("FAIL add_result: got %0d want %0d", result, e.res); end
        vecs++; if (salida !== seg(int'(e.res))) begin errs++; $display("FAIL add_salida: got %h want %h", salida, seg(int'(e.res))); end
        wait_idle(n);
        vecs++; if (n < 0) begin errs++; $display("FAIL add_idle: got timeout want busy low"); end
        tick();
        vecs++; if (result !== 4'd6) begin errs++; $display("FAIL add_hold_idle: got %0d want 6", result); end
        set0(1, 0, 2, 0);
        post(0, 0, 2, 0);
        wait_gnt(n);
        vecs++; if (n < 0 || gnt0 !== 1'b1) begin errs++; $display("FAIL zero_gnt: got n=%0d gnt0=%b want gnt0=1", n, gnt0); end
        set0(0, 0, 0, 0);
        tick();
        e = sb.pop_front();
        vecs++; if (result !== e.res) begin errs++; $display("FAIL zero_result: got %0d want %0d", result, e.res); end
        vecs++; if (salida !== seg(int'(e.res))) begin errs++; $display("FAIL zero_salida: got %h want %h", salida, seg(int'(e.res))); end
        wait_idle(n);
    endtask

    task automatic test_tie();
        exp_t e;
        int n;
        int m;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set0(1, 1, 1, 1);
        set1(1, 1, 3, 0);
        post(0, 1, 1, 1);
        post(1, 1, 3, 0);
        wait_gnt(n);
        vecs++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errs++; $display("FAIL tie_first: got %b%b want 10", gnt0, gnt1); end
        set0(0, 0, 0, 0);
        tick();
        e = sb.pop_front();
        vecs++; if (result !== e.res || owner !== e.owner) begin errs++; $display("FAIL tie_res0: got %0d/%b want %0d/%b", result, owner, e.res, e.owner); end
        wait_gnt(m);
        vecs++; if (m < 0 || m + 1 != 6) begin errs++; $display("FAIL tie_gap: got %0d want 6", m + 1); end
        vecs++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errs++; $display("FAIL tie_second: got %b%b want 01", gnt0, gnt1); end
        set1(0, 0, 0, 0);
        tick();
        e = sb.pop_front();
        vecs++; if (result !== e.res || owner !== e.owner) begin errs++; $display("FAIL tie_res1: got %0d/%b want %0d/%b", result, owner, e.res, e.owner); end
        vecs++; if (salida !== seg(int'(e.res))) begin errs++; $display("FAIL tie_salida1: got %h want %h", salida, seg(int'(e.res))); end
        wait_idle(n);
    endtask

    task automatic test_alternate();
        exp_t e;
        int got;
        int prev;
        int n;
        bit pend;
        got = 0;
        prev = -1;
        pend = 1'b0;
        set0(1, 1, 2, 1);
        set1(1, 2, 3, 0);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) post(0, 1, 2, 1);
            else post(1, 2, 3, 0);
        end
        for (int t = 1; t <= 60 && (got < 4 || pend); t++) begin
            tick();
            if (pend) begin
                pend = 1'b0;
                e = sb.pop_front();
                vecs++; if (result !== e.res || owner !== e.owner) begin errs++; $display("FAIL alt_res: got %0d/%b want %0d/%b", result, owner, e.res, e.owner); end
                if (got == 4) begin
                    set0(0, 0, 0, 0);
                    set1(0, 0, 0, 0);
                end
            end
            if (gnt0 || gnt1) begin
                vecs++; if (gnt0 && gnt1) begin errs++; $display("FAIL alt_onehot: got %b%b want one grant", gnt0, gnt1); end
                vecs++; if (gnt1 !== 1'((got % 2) == 1)) begin errs++; $display("FAIL alt_order: got gnt1=%b want %0d", gnt1, got % 2); end
                if (prev >= 0) begin
                    vecs++; if (t - prev != 6) begin errs++; $display("FAIL alt_gap: got %0d want 6", t - prev); end
                end
                prev = t;
                got++;
                pend = 1'b1;
            end
        end
        vecs++; if (got != 4) begin errs++; $display("FAIL alt_count: got %0d want 4", got); end
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        sb.delete();
        wait_idle(n);
    endtask

    task automatic test_hold_req();
        exp_t e;
        int n;
        set0(1, 2, 2, 0);
        post(0, 2, 2, 0);
        wait_gnt(n);
        vecs++; if (gnt0 !== 1'b1) begin errs++; $display("FAIL hreq_gnt0: got %b want 1", gnt0); end
        set0(0, 0, 0, 0);
        tick();
        e = sb.pop_front();
        vecs++; if (result !== e.res) begin errs++; $display("FAIL hreq_res0: got %0d want %0d", result, e.res); end
        tick();
        tick();
        set1(1, 1, 1, 1);
        post(1, 1, 1, 1);
        for (int i = 0; i < 20 && busy; i++) begin
            vecs++; if (gnt1 !== 1'b0) begin errs++; $display("FAIL hreq_early_gnt1: got %b want 0", gnt1); end
            vecs++; if (result !== 4'd4) begin errs++; $display("FAIL hreq_held: got %0d want 4", result); end
            tick();
        end
        vecs++; if (busy !== 1'b0 || gnt1 !== 1'b0) begin errs++; $display("FAIL hreq_idle: got busy=%b gnt1=%b want 0 0", busy, gnt1); end
        tick();
        vecs++; if (gnt1 !== 1'b1) begin errs++; $display("FAIL hreq_gnt1: got %b want 1", gnt1); end
        vecs++; if (result !== 4'd4) begin errs++; $display("FAIL hreq_pre: got %0d want 4", result); end
        set1(0, 0, 0, 0);
        tick();
        e = sb.pop_front();
        vecs++; if (result !== e.res || owner !== e.owner) begin errs++; $display("FAIL hreq_res1: got %0d/%b want %0d/%b", result, owner, e.res, e.owner); end
        wait_idle(n);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int n;
        set0(1, 3, 3, 0);
        post(0, 3, 3, 0);
        wait_gnt(n);
        set0(0, 0, 0, 0);
        tick();
        e = sb.pop_front();
        vecs++; if (result !== e.res) begin errs++; $display("FAIL rmid_res: got %0d want %0d", result, e.res); end
        tick();
        #2 rst = 1'b1;
        #1;
        vecs++; if (result !== 4'd0) begin errs++; $display("FAIL rmid_result: got %0d want 0", result); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rmid_busy: got %b want 0", busy); end
        vecs++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errs++; $display("FAIL rmid_gnt: got %b%b want 00", gnt0, gnt1); end
        vecs++; if (salida !== seg(0)) begin errs++; $display("FAIL rmid_salida: got %h want %h", salida, seg(0)); end
        tick();
        rst = 1'b0;
        set0(1, 1, 0, 1);
        set1(1, 0, 0, 1);
        post(0, 1, 0, 1);
        wait_gnt(n);
        vecs++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errs++; $display("FAIL rmid_tie: got %b%b want 10", gnt0, gnt1); end
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        tick();
        e = sb.pop_front();
        vecs++; if (result !== e.res || owner !== e.owner) begin errs++; $display("FAIL rmid_tie_res: got %0d/%b want %0d/%b", result, owner, e.res, e.owner); end
        wait_idle(n);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_add_zero();
        test_tie();
        test_alternate();
        test_hold_req();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
